aes256_inv_key_sched: RTL and testbench
=======================================

// Module: aes256_inv_key_sched
// PURPOSE
//  Sequential reverse AES-256 key scheduler for the decrypt datapath. Loads the final two round keys
//  (words w52..w59) and emits round keys 14,13,...,0, one 128-bit key per valid/ready handshake.
//  Each step undoes one forward schedule step: w[i-8] = w[i] ^ f(w[i-1]).
//  It feeds the inverse-round engine, which consumes keys last-round-first.
// PARAMETERS
//  None. localparams:
//   NR=14    number of rounds
//   NRK=15   number of round keys emitted
//   W0_IDX=52  index of the first word held by last_key
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    synchronous, active-high reset
//  start       in   1    load request; accepted only when busy==0
//  last_key    in   256  bit-ordered [0:255] = {w52,w53,...,w59}, each word big-endian bytes
//  busy        out  1    high from the accepting edge until the cycle after the final transfer
//  rk_valid    out  1    rk/rk_idx hold a round key
//  rk_ready    in   1    downstream accept; a transfer occurs when rk_valid && rk_ready
//  rk          out  128  round key, bit-ordered [0:127] = {w[4n],...,w[4n+3]}
//  rk_idx      out  4    round number n of rk: 14 down to 0
//  done        out  1    one-cycle pulse, the cycle after the rk_idx==0 transfer
// BEHAVIOUR
//  Reset values: busy=0, rk_valid=0, rk=0, rk_idx=0, done=0; state=IDLE.
//  Window register W[0..7] holds w[j..j+7]; j is a multiple of 4.
//  IDLE:
//   - start: W<=last_key, j<=52, go to EMIT_HI.
//   - start while busy is ignored, with no effect on the run.
//  EMIT_HI: rk=W[4..7], rk_idx=14, rk_valid=1. On transfer, go to EMIT_LO.
//  EMIT_LO: rk=W[0..3], rk_idx=j/4, rk_valid=1.
//   - Transfer with j==0: go to IDLE, done=1 for one cycle.
//   - Transfer with j>0: W<={nw0..nw3, W[0..3]}, j<=j-4, stay in EMIT_LO; the next key is valid
//     the very next cycle.
//  New words (computed combinationally from W; all operands are in the window):
//   nw0=w[j-4]=W[4]^g(W[3]); nw1=W[5]^W[4]; nw2=W[6]^W[5]; nw3=W[7]^W[6]
//   g = RotWord(SubWord(x)) ^ Rcon((j+4)/8) when (j+4)%8==0; g = SubWord(x) when (j+4)%8==4.
//   Rcon(r) = {rc[r],24'h0}, rc = 01,02,04,08,10,20,40 for r=1..7.
//  Transfer and outputs:
//   - Throughput: one key per cycle when rk_ready is held high; 15 transfers per run.
//   - rk/rk_idx are held stable while rk_valid && !rk_ready.
//   - rk_valid never drops without a transfer.
//  Boundaries:
//   - The final key (rk_idx=0) equals last-loaded W[0..3]; no further computation occurs.
//   - start in the same cycle as the final transfer is ignored (busy still 1).
//   - rst mid-run aborts immediately to the reset values; no done pulse.
//   - Only the registered W/j state and the combinational g datapath exist.
//     Latency from start accepted to first rk_valid is 1 cycle.
// CONFIGURATION
//  AES_INVKS_CIPHERKEY_EN defined:
//   - Adds ports cipher_key out 256 [0:255] and cipher_key_valid out 1 (both reset 0).
//   - At the rk_idx==0 transfer, cipher_key<={W[0..3],W[4..7]}=w0..w7; cipher_key_valid=1 with done.
//   - Both hold until the next accepted start or rst, which clears them.
//  Not defined: these ports and their registers are absent; all other behaviour is identical.
// STRUCTURE
//  - Shared package aes_pkg: S-box function, Rcon function/table, RotWord/SubWord word helpers, word
//    typedef [0:31]. The forward key expansion uses the same package.
//  - One sub-module: aes_subword (4 parallel S-box lookups, 32-bit in/out), one instance on W[3].
//  - State enum {IDLE,EMIT_HI,EMIT_LO} stays local to this module.
// TESTING
//  1. FIPS-197 key 000102..1f, last_key=w52..w59 from the software model, rk_ready=1:
//     - rk_idx14 = 24fc79ccbf0979e9371ac23c6d68de36
//     - rk_idx1 = 101112131415161718191a1b1c1d1e1f
//     - rk_idx0 = 000102030405060708090a0b0c0d0e0f
//     - 15 transfers in 15 consecutive cycles, done 1 cycle later.
//  2. Cross-check against the forward expansion for 100 random keys: last_key=keyschedule[1664:1919];
//     every rk_idx n equals keyschedule[128n +: 128].
//  3. Backpressure with random rk_ready (~30% duty): rk/rk_idx stable while stalled, order 14..0,
//     no drops or duplicates.
//  4. start pulsed mid-run at rk_idx 7: ignored, sequence completes unchanged. start coincident with
//     the final transfer: ignored.
//  5. rst asserted at rk_idx 9: next cycle rk_valid=0, busy=0, done never pulses. A new start then
//     yields a correct full run.
//  6. AES_INVKS_CIPHERKEY_EN on, key from test 1: cipher_key=000102..1f with done, cleared by the
//     next start.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: byte S-box, Rcon table and the RotWord/SubWord word operations.
// Used by both the forward and the reverse key schedulers.
package aes_pkg;

    typedef logic [0:31] word_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) inv = gf_mul(gf_mul(inv, inv), x);
        inv = gf_mul(inv, inv);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic word_t rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h000000};
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[8:31], w[0:7]};
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[0:7]), sbox(w[8:15]), sbox(w[16:23]), sbox(w[24:31])};
    endfunction

endpackage

// File: rtl/aes256_inv_key_sched_if.sv
// Round-key stream from the reverse scheduler to the inverse-round engine (valid/ready).
interface aes256_inv_key_sched_if;
    logic         rk_valid;
    logic         rk_ready;
    logic [0:127] rk;
    logic [3:0]   rk_idx;

    modport master (output rk_valid, output rk, output rk_idx, input rk_ready);
    modport slave  (input rk_valid, input rk, input rk_idx, output rk_ready);
endinterface

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);
    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_o[8*b +: 8] = sbox(word_i[8*b +: 8]);
    end
endmodule

// File: rtl/aes256_inv_key_sched.sv
// Reverse AES-256 key scheduler: loads w52..w59 and streams round keys 14..0 over valid/ready.
// Optional AES_INVKS_CIPHERKEY_EN also exposes the recovered cipher key w0..w7 after the run.
module aes256_inv_key_sched
    import aes_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [0:255]                  last_key,
    output logic                          busy,
    aes256_inv_key_sched_if.master        rk_if,
    output logic                          done
`ifdef AES_INVKS_CIPHERKEY_EN
    ,
    output logic [0:255]                  cipher_key,
    output logic                          cipher_key_valid
`endif
);
    localparam int NR     = 14;
    localparam int NRK    = NR + 1;
    localparam int W0_IDX = 52;

    typedef enum logic [1:0] {IDLE, EMIT_HI, EMIT_LO} state_e;

    state_e                   state_q, state_d;
    word_t                    w_q [8];
    word_t                    w_d [8];
    logic [$clog2(NRK)-1:0]   idx_q, idx_d;   // j/4: round number of W[0..3]
    logic                     done_q, done_d;
    word_t                    sub_w, g_w;

    aes_subword u_subword (.word_i(w_q[3]), .word_o(sub_w));

    // Odd j/4 means (j+4) is a multiple of 8: the RotWord+Rcon step of the forward schedule.
    assign g_w = idx_q[0] ? (rot_word(sub_w) ^ rcon((idx_q + 4'd1) >> 1)) : sub_w;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d        = state_q;
        idx_d          = idx_q;
        w_d            = w_q;
        done_d         = 1'b0;
        rk_if.rk_valid = 1'b0;
        rk_if.rk       = '0;
        rk_if.rk_idx   = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < 8; k++) w_d[k] = last_key[32*k +: 32];
                    idx_d   = 4'(W0_IDX / 4);
                    state_d = EMIT_HI;
                end
            end
            EMIT_HI: begin
                rk_if.rk_valid = 1'b1;
                rk_if.rk       = {w_q[4], w_q[5], w_q[6], w_q[7]};
                rk_if.rk_idx   = 4'(NR);
                if (rk_if.rk_ready) state_d = EMIT_LO;
            end
            EMIT_LO: begin
                rk_if.rk_valid = 1'b1;
                rk_if.rk       = {w_q[0], w_q[1], w_q[2], w_q[3]};
                rk_if.rk_idx   = idx_q;
                if (rk_if.rk_ready) begin
                    if (idx_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        w_d   = '{w_q[4] ^ g_w, w_q[5] ^ w_q[4], w_q[6] ^ w_q[5], w_q[7] ^ w_q[6],
                                  w_q[0], w_q[1], w_q[2], w_q[3]};
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the key window is datapath only; outputs are gated by state, so it needs no reset.
    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

`ifdef AES_INVKS_CIPHERKEY_EN
    logic [0:255] ck_q;
    logic         ckv_q;

    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && start)) begin
            ck_q  <= '0;
            ckv_q <= 1'b0;
        end else if (state_q == EMIT_LO && idx_q == '0 && rk_if.rk_ready) begin
            ck_q  <= {w_q[0], w_q[1], w_q[2], w_q[3], w_q[4], w_q[5], w_q[6], w_q[7]};
            ckv_q <= 1'b1;
        end
    end

    assign cipher_key       = ck_q;
    assign cipher_key_valid = ckv_q;
`endif

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// Bench for aes256_inv_key_sched: forward-expansion model plus a per-cycle stream model.
// Build with AES_INVKS_CIPHERKEY_EN defined to also check the recovered cipher key.
module tb_aes256_inv_key_sched;

    logic         clk;
    logic         rst;
    logic         start;
    logic [0:255] last_key;
    logic         busy;
    logic         done;
`ifdef AES_INVKS_CIPHERKEY_EN
    logic [0:255] cipher_key;
    logic         cipher_key_valid;
`endif

    aes256_inv_key_sched_if rk_if ();

    aes256_inv_key_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .last_key (last_key),
        .busy     (busy),
        .rk_if    (rk_if),
        .done     (done)
`ifdef AES_INVKS_CIPHERKEY_EN
        ,
        .cipher_key       (cipher_key),
        .cipher_key_valid (cipher_key_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Standard AES S-box table, independent of the RTL's GF(2^8) construction.
    logic [0:2047] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        return sbox_tab[8*x +: 8];
    endfunction

    function automatic logic [31:0] tb_subw(input logic [31:0] t);
        return {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: forward FIPS-197 expansion; round key n is words w[4n..4n+3].
    logic [127:0] exp_rk [15];
    logic [255:0] exp_ck;
    logic [255:0] exp_lk;

    task automatic load_model(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0)      t = tb_subw({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
            else if (i % 8 == 4) t = tb_subw(t);
            w[i] = w[i-8] ^ t;
        end
        for (int n = 0; n < 15; n++) exp_rk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
        exp_ck = {w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7]};
        exp_lk = {w[52], w[53], w[54], w[55], w[56], w[57], w[58], w[59]};
    endtask

    // Stream model: which key index must be on the bus this cycle, if any.
    bit           m_active = 1'b0;
    int           m_idx    = 0;
    bit           m_done   = 1'b0;
    bit           m_ckv    = 1'b0;
    logic [255:0] m_ck     = '0;

    always @(negedge clk) begin
        bit nd;
        check("busy", busy, m_active);
        check("done", done, m_done);
        check("rk_valid", rk_if.rk_valid, m_active);
        if (m_active) begin
            check("rk_idx", rk_if.rk_idx, m_idx);
            check($sformatf("rk[%0d]", m_idx), rk_if.rk, exp_rk[m_idx]);
        end
`ifdef AES_INVKS_CIPHERKEY_EN
        check("cipher_key_valid", cipher_key_valid, m_ckv);
        check("cipher_key", cipher_key, m_ckv ? m_ck : 256'h0);
`endif
        nd = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_ckv    = 1'b0;
            m_ck     = '0;
        end else if (m_active && rk_if.rk_ready) begin
            if (m_idx == 0) begin
                m_active = 1'b0;
                nd       = 1'b1;
                m_ckv    = 1'b1;
                m_ck     = exp_ck;
            end else begin
                m_idx--;
            end
        end else if (!m_active && start) begin
            m_active = 1'b1;
            m_idx    = 14;
            m_ckv    = 1'b0;
            m_ck     = '0;
        end
        m_done = nd;
    end

    // One run: random ready duty, optional start pokes at poke_idx / the final transfer,
    // optional reset when rst_idx is on the bus.
    task automatic run(input logic [255:0] key, input int pct, input int poke_idx,
                       input bit poke_final, input int rst_idx);
        int cyc;
        bit fin;
        bit got_done;
        load_model(key);
        @(posedge clk); #1;
        last_key = exp_lk;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
`ifdef AES_INVKS_CIPHERKEY_EN
        check("ck_cleared_by_start", cipher_key_valid, 1'b0);
`endif
        cyc = 0; fin = 1'b0; got_done = 1'b0;
        while (!fin && cyc < 2000) begin
            rk_if.rk_ready = ($urandom_range(99) < pct);
            if (poke_idx >= 0 && rk_if.rk_valid && rk_if.rk_idx == poke_idx) begin
                start    = 1'b1;
                last_key = rand256();
            end
            if (poke_final && rk_if.rk_valid && rk_if.rk_idx == 0) begin
                rk_if.rk_ready = 1'b1;
                start          = 1'b1;
            end
            if (rst_idx >= 0 && rk_if.rk_valid && rk_if.rk_idx == rst_idx) begin
                rst = 1'b1;
                fin = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            rst   = 1'b0;
            if (done) begin
                fin      = 1'b1;
                got_done = 1'b1;
            end
        end
        if (rst_idx >= 0) begin
            check("rst_rk_valid", rk_if.rk_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_reached", fin, 1'b1);
            repeat (20) @(posedge clk);
            #1;
        end else begin
            check("run_done", got_done, 1'b1);
            if (pct >= 100) check("run_cycles", cyc, 15);
        end
    endtask

    initial begin
        logic [255:0] fips_key;
        fips_key       = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        rst            = 1'b1;
        start          = 1'b0;
        last_key       = '0;
        rk_if.rk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rk", rk_if.rk, 128'h0);
        check("reset_rk_idx", rk_if.rk_idx, 4'h0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;

        load_model(fips_key);
        check("model_rk14", exp_rk[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        check("model_rk1", exp_rk[1], 128'h101112131415161718191a1b1c1d1e1f);
        check("model_rk0", exp_rk[0], 128'h000102030405060708090a0b0c0d0e0f);

        run(fips_key, 100, -1, 1'b0, -1);
`ifdef AES_INVKS_CIPHERKEY_EN
        check("ck_fips", cipher_key, fips_key);
        check("ck_fips_valid", cipher_key_valid, 1'b1);
`endif

        repeat (100) run(rand256(), 100, -1, 1'b0, -1);
        repeat (8)   run(rand256(), 30, -1, 1'b0, -1);
        run(rand256(), 60, 7, 1'b1, -1);
        run(fips_key, 100, 7, 1'b1, -1);
        run(rand256(), 70, -1, 1'b0, 9);
        run(fips_key, 100, -1, 1'b0, -1);
        run(rand256(), 50, -1, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
